// File: rtl/unary_add_n_if.sv
// unary_add_n_if: control, unary input and readout signals of the unary accumulator
interface unary_add_n_if #(
  parameter int N_IN  = 2,
  parameter int CNT_W = 8
);
  logic             en;
  logic [N_IN-1:0]  din;
  logic             clear;
  logic             read_or_write;
  logic             dout;
  logic             C;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             done;
  modport master (
    output en, din, clear, read_or_write,
    input  dout, C, count, busy, done
  );
  modport slave (
    input  en, din, clear, read_or_write,
    output dout, C, count, busy, done
  );
endinterface

// File: rtl/unary_add_n.sv
// unary_add_n: sums N_IN unary streams into a count with overflow flag, then replays it as a unary stream
module unary_add_n #(
  parameter int N_IN     = 2,
  parameter int CNT_W    = 8,
  parameter bit SATURATE = 1'b0
) (
  input logic          clk,
  input logic          rst,
  unary_add_n_if.slave bus
);
  localparam int ONES_W = $clog2(N_IN + 1);
  localparam int SUM_W  = CNT_W + 1;
  typedef enum logic [1:0] {ACC, READ, DONE} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0]  count_r, count_nx, rem, rem_nx;
  logic              c_r, c_nx, dout_r, dout_nx;
  logic [ONES_W-1:0] ones;
  logic [SUM_W-1:0]  sum;
  logic              ovf, rw;
  assign rw = bus.read_or_write;
  always_ff @(posedge clk)
    if (rst) state <= ACC;
    else if (bus.en) state <= state_nx;
  always_comb
    state_nx = state == ACC  ? (rw ? READ : ACC) :
               state == READ ? (!rw ? ACC : rem == '0 ? DONE : READ) :
                               (rw ? DONE : ACC);
  always_comb begin
    ones = '0;
    for (int i = 0; i < N_IN; i++) ones = ones + ONES_W'(bus.din[i]);
  end
  assign sum = {1'b0, count_r} + SUM_W'(ones);
  assign ovf = sum > {1'b0, {CNT_W{1'b1}}};
  // clear only touches count/C; the state walk and readout continue around it
  always_comb begin
    count_nx = count_r;
    c_nx     = c_r;
    rem_nx   = rem;
    dout_nx  = 1'b0;
    if (bus.clear) begin
      count_nx = '0;
      c_nx     = 1'b0;
    end else if (state == ACC && !rw) begin
      count_nx = !ovf ? sum[CNT_W-1:0] : SATURATE ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
      c_nx     = c_r | ovf;
    end
    if (state == ACC && rw) rem_nx = count_r;
    if (state == READ && rw && rem != '0) begin
      dout_nx = 1'b1;
      rem_nx  = rem - 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      count_r <= '0;
      c_r     <= 1'b0;
      rem     <= '0;
      dout_r  <= 1'b0;
    end else if (bus.en) begin
      count_r <= count_nx;
      c_r     <= c_nx;
      rem     <= rem_nx;
      dout_r  <= dout_nx;
    end
  always_comb begin
    bus.busy  = state == READ;
    bus.done  = state == DONE;
    bus.count = count_r;
    bus.C     = c_r;
    bus.dout  = dout_r;
  end
endmodule

// File: tb/tb_unary_add_n.sv
// tb_unary_add_n: directed checks of accumulate, overflow (wrap and saturate) and unary readout
module tb_unary_add_n;
  logic       clk = 1'b0;
  logic       rst, en, clear, rw;
  logic [1:0] din;
  int         total = 0, bad = 0, ones;
  always #5 clk = ~clk;
  unary_add_n_if #(.N_IN(2), .CNT_W(8)) bw ();
  unary_add_n_if #(.N_IN(2), .CNT_W(8)) bs ();
  assign bw.en = en;
  assign bw.din = din;
  assign bw.clear = clear;
  assign bw.read_or_write = rw;
  assign bs.en = en;
  assign bs.din = din;
  assign bs.clear = clear;
  assign bs.read_or_write = rw;
  unary_add_n #(.N_IN(2), .CNT_W(8), .SATURATE(1'b0)) u_wrap (.clk(clk), .rst(rst), .bus(bw.slave));
  unary_add_n #(.N_IN(2), .CNT_W(8), .SATURATE(1'b1)) u_sat  (.clk(clk), .rst(rst), .bus(bs.slave));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic load11;
    din = 2'b01;
    step(5);
    din = 2'b11;
    step(3);
    din = 2'b00;
  endtask
  initial begin
    rst = 1'b1; en = 1'b1; clear = 1'b0; rw = 1'b0; din = 2'b00;
    step(2);
    check("rst_count", bw.count, 0);
    check("rst_c", bw.C, 0);
    check("rst_dout", bw.dout, 0);
    check("rst_busy", bw.busy, 0);
    check("rst_done", bw.done, 0);
    check("rst_sat_count", bs.count, 0);
    rst = 1'b0;
    din = 2'b11;
    step(129);
    check("wrap_count", bw.count, 2);
    check("wrap_c", bw.C, 1);
    check("sat_count", bs.count, 255);
    check("sat_c", bs.C, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    din = 2'b00;
    check("clear_count", bw.count, 0);
    check("clear_c", bw.C, 0);
    check("clear_sat_count", bs.count, 0);
    load11();
    check("acc_count", bw.count, 11);
    check("acc_c", bw.C, 0);
    rw = 1'b1;
    step();
    check("rd_busy", bw.busy, 1);
    check("rd_first_dout", bw.dout, 0);
    ones = 0;
    for (int i = 0; i < 11; i++) begin
      step();
      ones += int'(bw.dout);
    end
    check("rd_ones", ones, 11);
    step();
    check("rd_end_dout", bw.dout, 0);
    check("rd_done", bw.done, 1);
    check("rd_end_busy", bw.busy, 0);
    check("rd_count_kept", bw.count, 11);
    step(2);
    check("done_hold", bw.done, 1);
    rw = 1'b0;
    step();
    check("done_exit", bw.done, 0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    rw = 1'b1;
    step();
    check("zero_busy", bw.busy, 1);
    check("zero_dout", bw.dout, 0);
    step();
    check("zero_dout2", bw.dout, 0);
    check("zero_done", bw.done, 1);
    check("zero_busy2", bw.busy, 0);
    rw = 1'b0;
    step();
    load11();
    rw = 1'b1;
    step();
    ones = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      ones += int'(bw.dout);
    end
    en = 1'b0;
    step(4);
    check("hold_dout", bw.dout, 1);
    check("hold_busy", bw.busy, 1);
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      ones += int'(bw.dout);
    end
    check("hold_ones", ones, 11);
    step();
    check("hold_done", bw.done, 1);
    check("hold_end_dout", bw.dout, 0);
    rw = 1'b0;
    step();
    rw = 1'b1;
    step(6);
    check("abort_pre_dout", bw.dout, 1);
    rw = 1'b0;
    step();
    check("abort_dout", bw.dout, 0);
    check("abort_busy", bw.busy, 0);
    check("abort_done", bw.done, 0);
    check("abort_count", bw.count, 11);
    rw = 1'b1;
    step(3);
    check("pre_rst_busy", bw.busy, 1);
    rst = 1'b1;
    step();
    check("rrst_dout", bw.dout, 0);
    check("rrst_busy", bw.busy, 0);
    check("rrst_done", bw.done, 0);
    check("rrst_count", bw.count, 0);
    check("rrst_c", bw.C, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
